ram_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters: port 0 (CPU load/store unit) and port 1 (program loader / debug port).
- Sequences each access through a fixed 4-state cycle and returns read data with a one-cycle ack pulse.
- Sits between the CPU memory interface and the RAM, inside the top-level core.
- Uses two-way round-robin arbitration so neither requester starves.

---
 rtl/ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a single-port synchronous RAM: every access runs IDLE->ISSUE->WAIT->DONE.
// Define RAM_ARB_STATS_EN to add saturating grant/conflict counters as outputs.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]           grant_cnt0,
   output logic [15:0]           grant_cnt1,
   output logic [15:0]           conflict_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  op_we_q, op_we_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

   logic grant_valid;
   logic grant_port;
   logic conflict;

   // On a tie the port that did not win last time goes next, so neither side starves.
   always_comb begin
      conflict    = req0 && req1;
      grant_valid = (state_q == S_IDLE) && (req0 || req1);
      grant_port  = conflict ? ~last_grant_q : req1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (grant_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
      endcase
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      op_we_d      = op_we_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               owner_d      = grant_port;
               last_grant_d = grant_port;
               op_we_d      = grant_port ? we1 : we0;
               ram_en_d     = 1'b1;
               ram_we_d     = grant_port ? we1 : we0;
               ram_addr_d   = grant_port ? addr1 : addr0;
               ram_wdata_d  = grant_port ? wdata1 : wdata0;
            end
         end
         S_WAIT: begin
            // ram_rdata is valid now, one cycle after the RAM sampled the command.
            if (owner_q) begin
               ack1_d = 1'b1;
               if (!op_we_q) rdata1_d = ram_rdata;
            end else begin
               ack0_d = 1'b1;
               if (!op_we_q) rdata0_d = ram_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_we_q      <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         op_we_q      <= op_we_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

`ifdef RAM_ARB_STATS_EN
   logic [15:0] grant_cnt0_q, grant_cnt0_d;
   logic [15:0] grant_cnt1_q, grant_cnt1_d;
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      grant_cnt0_d   = grant_cnt0_q;
      grant_cnt1_d   = grant_cnt1_q;
      conflict_cnt_d = conflict_cnt_q;
      if (grant_valid) begin
         if (!grant_port && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
         if (grant_port && grant_cnt1_q != 16'hFFFF)  grant_cnt1_d = grant_cnt1_q + 16'd1;
         if (conflict && conflict_cnt_q != 16'hFFFF)  conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0_q   <= '0;
         grant_cnt1_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt0_q   <= grant_cnt0_d;
         grant_cnt1_q   <= grant_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign grant_cnt0   = grant_cnt0_q;
   assign grant_cnt1   = grant_cnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized requesters against a
// transaction-level model (grant time, fixed access latency, round-robin tie rule, reference memory).
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, ack1;
   logic [15:0] rdata0, rdata1;
   logic        ram_en, ram_we;
   logic [15:0] ram_addr, ram_wdata, ram_rdata;
   logic        mem_clear;
`ifdef RAM_ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
`ifdef RAM_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
   );

   // Synchronous RAM: decodes the low address byte, read data appears the cycle after the command.
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr[7:0]];
      end
   end

   int checks   = 0;
   int failures = 0;
   int e        = 0;

   // Model state: one transaction in flight, timed from the edge it was granted.
   logic [15:0] ref_mem [256];
   bit          m_busy, m_last, m_port, m_we;
   int          m_g;
   logic [15:0] m_rexp;
   logic        x_en, x_we, x_ack0, x_ack1;
   logic [15:0] x_addr, x_wdata, x_rd0, x_rd1;
`ifdef RAM_ARB_STATS_EN
   logic [15:0] x_gc0, x_gc1, x_cc;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, e, act, exp);
      end
   endtask

   // Predict the outputs that follow the coming rising edge, given the inputs now applied.
   task automatic predict();
      bit p;
      if (reset) begin
         x_en = 0; x_we = 0; x_addr = 0; x_wdata = 0;
         x_ack0 = 0; x_ack1 = 0; x_rd0 = 0; x_rd1 = 0;
         m_last = 1; m_busy = 0;
`ifdef RAM_ARB_STATS_EN
         x_gc0 = 0; x_gc1 = 0; x_cc = 0;
`endif
      end else if (!m_busy) begin
         x_en = 0; x_we = 0; x_ack0 = 0; x_ack1 = 0;
         if (req0 || req1) begin
            p = (req0 && req1) ? !m_last : req1;
`ifdef RAM_ARB_STATS_EN
            if (!p && x_gc0 != 16'hFFFF) x_gc0++;
            if (p && x_gc1 != 16'hFFFF) x_gc1++;
            if (req0 && req1 && x_cc != 16'hFFFF) x_cc++;
`endif
            m_last = p; m_port = p; m_busy = 1; m_g = e;
            m_we    = p ? we1 : we0;
            x_addr  = p ? addr1 : addr0;
            x_wdata = p ? wdata1 : wdata0;
            if (m_we) ref_mem[x_addr[7:0]] = x_wdata;
            else      m_rexp = ref_mem[x_addr[7:0]];
            x_en = 1; x_we = m_we;
         end
      end else begin
         case (e - m_g)
            1: begin x_en = 0; x_we = 0; end
            2: begin
               if (m_port) x_ack1 = 1; else x_ack0 = 1;
               if (!m_we) begin
                  if (m_port) x_rd1 = m_rexp; else x_rd0 = m_rexp;
               end
            end
            default: begin x_ack0 = 0; x_ack1 = 0; m_busy = 0; end
         endcase
      end
      e++;
   endtask

   task automatic compare();
      chk("ram_en", ram_en, x_en);
      chk("ram_we", ram_we, x_we);
      chk("ram_addr", ram_addr, x_addr);
      chk("ram_wdata", ram_wdata, x_wdata);
      chk("ack0", ack0, x_ack0);
      chk("ack1", ack1, x_ack1);
      chk("rdata0", rdata0, x_rd0);
      chk("rdata1", rdata1, x_rd1);
      chk("ack_exclusive", ack0 & ack1, 0);
`ifdef RAM_ARB_STATS_EN
      chk("grant_cnt0", grant_cnt0, x_gc0);
      chk("grant_cnt1", grant_cnt1, x_gc1);
      chk("conflict_cnt", conflict_cnt, x_cc);
`endif
   endtask

   task automatic cycle();
      predict();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   // Runs cycles until the port acks; n counts edges taken, bounded by limit.
   task automatic wait_ack(input bit port, input int limit, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(port ? ack1 : ack0) && n < limit);
      chk(port ? "ack1_arrives" : "ack0_arrives", port ? ack1 : ack0, 1);
   endtask

   task automatic new_req(input bit p);
      logic [15:0] a;
      a = 16'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 16'hA500 : 16'h0000);
      if (p) begin
         req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = a; wdata1 = 16'($urandom);
      end else begin
         req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = a; wdata0 = 16'($urandom);
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      m_busy = 0; m_last = 1; m_port = 0; m_we = 0; m_g = 0; m_rexp = 0;
      mem_clear = 1; reset = 1;
      wdata0 = 0; wdata1 = 0;

      // Reset held two cycles with both ports requesting.
      req0 = 1; we0 = 0; addr0 = 16'h0A0A;
      req1 = 1; we1 = 0; addr1 = 16'h0B0B;
      cycle();
      mem_clear = 0;
      cycle();
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_acks", {ack0, ack1}, 0);
      chk("rst_rdata", {rdata0, rdata1}, 0);
      reset = 0;
      cycle();
      chk("first_grant_en", ram_en, 1);
      chk("first_grant_addr", ram_addr, 16'h0A0A);
      wait_ack(0, 8, n);
      chk("first_ack_latency", n, 2);
      req0 = 0;
      wait_ack(1, 8, n);
      chk("loser_served_next", n, 4);
      req1 = 0;
      cycle();

      // Port 0 write then read back.
      req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
      wait_ack(0, 8, n);
      chk("write_latency", n, 3);
      req0 = 0;
      cycle();
      req0 = 1; we0 = 0;
      wait_ack(0, 8, n);
      chk("read_latency", n, 3);
      chk("read_beef", rdata0, 16'hBEEF);
      req0 = 0;
      cycle();

      // Preload 0x0001/0x0002 through port 1.
      for (int k = 1; k <= 2; k++) begin
         req1 = 1; we1 = 1; addr1 = 16'(k); wdata1 = 16'(k * 16'h1111);
         wait_ack(1, 8, n);
         req1 = 0;
         cycle();
      end

      // Tie from reset: port 0, then port 1, then port 0 again.
      reset = 1;
      req0 = 1; we0 = 0; addr0 = 16'h0001;
      req1 = 1; we1 = 0; addr1 = 16'h0002;
      cycle();
      reset = 0;
      wait_ack(0, 8, n);
      chk("tie_first_data", rdata0, 16'h1111);
      chk("tie_first_latency", n, 3);
      wait_ack(1, 8, n);
      chk("tie_second_data", rdata1, 16'h2222);
      chk("tie_second_latency", n, 4);
      wait_ack(0, 8, n);
      chk("tie_third_is_port0", n, 4);

      // Port 1 streaming; port 0 joins mid-access and accesses alternate.
      req0 = 0;
      wait_ack(1, 8, n);
      cycle();
      cycle();
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      wait_ack(1, 8, n);
      chk("stream_1_finish", n, 2);
      wait_ack(0, 8, n);
      chk("stream_0_turn", n, 4);
      wait_ack(1, 8, n);
      chk("stream_1_turn", n, 4);
      wait_ack(0, 8, n);
      chk("stream_0_turn2", n, 4);
      req0 = 0; req1 = 0;
      cycle();

      // Reset during WAIT of a port 1 read.
      req1 = 1; we1 = 0; addr1 = 16'h0002;
      cycle();
      cycle();
      reset = 1; req1 = 0;
      cycle();
      chk("rst_wait_ack1", ack1, 0);
      chk("rst_wait_rdata1", rdata1, 0);
      reset = 0;
      for (int i = 0; i < 4; i++) cycle();
      chk("rst_wait_no_late_ack", ack1, 0);
      req1 = 1;
      wait_ack(1, 8, n);
      chk("after_rst_latency", n, 3);
      chk("after_rst_data", rdata1, 16'h2222);
      req1 = 0;
      cycle();

      // Randomized requesters with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if (req0 && ack0) begin
            if ($urandom_range(0, 1) == 1) new_req(0); else req0 = 0;
         end else if (!req0 && $urandom_range(0, 2) == 0) new_req(0);
         if (req1 && ack1) begin
            if ($urandom_range(0, 1) == 1) new_req(1); else req1 = 0;
         end else if (!req1 && $urandom_range(0, 2) == 0) new_req(1);
         reset = ($urandom_range(0, 79) == 0);
         cycle();
      end
      reset = 0; req0 = 0; req1 = 0;
      for (int i = 0; i < 6; i++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
